// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The arbiter uses the slave modport; the requesters/memory use the master modport.
interface mem_port_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_PORTS-1:0]            i_req;
    logic [NUM_PORTS-1:0]            i_rw;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] i_address;
    logic [NUM_PORTS*DATA_WIDTH-1:0] i_data;
    logic [NUM_PORTS*DATA_WIDTH-1:0] o_data;
    logic [NUM_PORTS-1:0]            o_ack;
    logic                            o_busy;
    logic                            o_mem_en;
    logic                            o_mem_wea;
    logic [ADDR_WIDTH-1:0]           o_mem_address;
    logic [DATA_WIDTH-1:0]           o_mem_data;
    logic [DATA_WIDTH-1:0]           i_mem_data;

    modport slave (
        input  i_req, i_rw, i_address, i_data, i_mem_data,
        output o_data, o_ack, o_busy, o_mem_en, o_mem_wea, o_mem_address, o_mem_data
    );

    modport master (
        output i_req, i_rw, i_address, i_data, i_mem_data,
        input  o_data, o_ack, o_busy, o_mem_en, o_mem_wea, o_mem_address, o_mem_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Multi-port arbiter sharing one single-port memory: fixed-priority or round-robin grant,
// one access in flight, fixed memory read latency, per-port read-data hold registers.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ARB_MODE    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    mem_port_arbiter_if.slave     io_bus
);
    localparam int unsigned IdxW = $clog2(NUM_PORTS);
    localparam logic [1:0] WaitInit = 2'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

    typedef logic [IdxW-1:0] idx_t;
    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_t;

    state_t                  r_state;
    idx_t                    r_grant;
    idx_t                    r_last_grant;
    logic                    r_rw;
    logic [1:0]              r_wait_cnt;
    logic [NUM_PORTS-1:0]    r_ack;
    logic                    r_busy;
    logic                    r_mem_en;
    logic                    r_mem_wea;
    logic [ADDR_WIDTH-1:0]   r_mem_address;
    logic [DATA_WIDTH-1:0]   r_mem_data;
    logic [DATA_WIDTH-1:0]   r_hold [NUM_PORTS];

    logic                            w_found;
    idx_t                            w_pick;
    int unsigned                     w_cand;
    logic [ADDR_WIDTH-1:0]           w_addr;
    logic [DATA_WIDTH-1:0]           w_wdata;
    logic [NUM_PORTS*DATA_WIDTH-1:0] w_o_data;

    // Candidate order: 0..N-1 for fixed priority, last_grant+1.. wrapping for round-robin.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == 0) begin
                w_cand = k;
            end else begin
                w_cand = 32'(r_last_grant) + 32'd1 + k;
                if (w_cand >= NUM_PORTS) begin
                    w_cand = w_cand - NUM_PORTS;
                end
            end
            if (!w_found && io_bus.i_req[idx_t'(w_cand)]) begin
                w_found = 1'b1;
                w_pick  = idx_t'(w_cand);
            end
        end
    end

    assign w_addr  = io_bus.i_address[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata = io_bus.i_data[w_pick*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_grant       <= '0;
            r_last_grant  <= idx_t'(NUM_PORTS - 1);
            r_rw          <= 1'b0;
            r_wait_cnt    <= '0;
            r_ack         <= '0;
            r_busy        <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_wea     <= 1'b0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                r_hold[p] <= '0;
            end
        end else begin
            r_ack <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state       <= StAccess;
                        r_busy        <= 1'b1;
                        r_grant       <= w_pick;
                        r_last_grant  <= w_pick;
                        r_rw          <= io_bus.i_rw[w_pick];
                        r_mem_en      <= 1'b1;
                        r_mem_wea     <= ~io_bus.i_rw[w_pick];
                        r_mem_address <= w_addr;
                        r_mem_data    <= w_wdata;
                    end
                end
                StAccess: begin
                    r_mem_en  <= 1'b0;
                    r_mem_wea <= 1'b0;
                    if (MEM_LATENCY == 1) begin
                        r_state        <= StDone;
                        r_ack[r_grant] <= 1'b1;
                    end else begin
                        r_state    <= StWait;
                        r_wait_cnt <= WaitInit;
                    end
                end
                StWait: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_state        <= StDone;
                        r_ack[r_grant] <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    if (r_rw) begin
                        r_hold[r_grant] <= io_bus.i_mem_data;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Read data bypasses the hold register during the ack cycle.
    always_comb begin
        w_o_data = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_o_data[p*DATA_WIDTH +: DATA_WIDTH] = (r_ack[p] && r_rw) ? io_bus.i_mem_data
                                                                       : r_hold[p];
        end
    end

    assign io_bus.o_data        = w_o_data;
    assign io_bus.o_ack         = r_ack;
    assign io_bus.o_busy        = r_busy;
    assign io_bus.o_mem_en      = r_mem_en;
    assign io_bus.o_mem_wea     = r_mem_wea;
    assign io_bus.o_mem_address = r_mem_address;
    assign io_bus.o_mem_data    = r_mem_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench: three arbiter configurations share a bench memory model;
// expected acks (port, data, cycle) are queued at stimulus time and popped on each o_ack.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_a ();
    mem_port_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_b ();
    mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_c ();

    mem_port_arbiter #(
        .NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(1), .ARB_MODE(0)
    ) u_dut_a (.i_clk(clk), .i_reset(rst_a), .io_bus(bus_a));

    mem_port_arbiter #(
        .NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(1), .ARB_MODE(0)
    ) u_dut_b (.i_clk(clk), .i_reset(rst_b), .io_bus(bus_b));

    mem_port_arbiter #(
        .NUM_PORTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(3), .ARB_MODE(1)
    ) u_dut_c (.i_clk(clk), .i_reset(rst_c), .io_bus(bus_c));

    // Memory model: writes from DUT A or the bench backdoor; read data follows the last read address.
    logic [7:0] mem [256];
    logic [7:0] rd_a, rd_b, rd_c;
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (bus_a.o_mem_en && bus_a.o_mem_wea) mem[bus_a.o_mem_address[7:0]] <= bus_a.o_mem_data;
        if (bus_a.o_mem_en && !bus_a.o_mem_wea) rd_a <= bus_a.o_mem_address[7:0];
        if (bus_b.o_mem_en && !bus_b.o_mem_wea) rd_b <= bus_b.o_mem_address[7:0];
        if (bus_c.o_mem_en && !bus_c.o_mem_wea) rd_c <= bus_c.o_mem_address[7:0];
    end

    assign bus_a.i_mem_data = mem[rd_a];
    assign bus_b.i_mem_data = mem[rd_b];
    assign bus_c.i_mem_data = mem[rd_c];

    typedef struct {
        int         port;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q [3][$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [7:0] pre_addr [6] = '{8'h34, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    logic [7:0] pre_data [6] = '{8'hA5, 8'h50, 8'h51, 8'h52, 8'h53, 8'h11};

    function automatic exp_t mk(input int port, input logic [7:0] data, input int at);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = at;
        return e;
    endfunction

    function automatic int first_one(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic mon(input int d, input logic [7:0] ack, input logic [63:0] od);
        exp_t e;
        int   p;
        if (ack != 8'h00) begin
            chk($sformatf("dut%0d_ack_onehot", d), 32'($onehot(ack)), 32'd1);
            if (q[d].size() == 0) begin
                chk($sformatf("dut%0d_unexpected_ack", d), 32'(ack), 32'd0);
            end else begin
                e = q[d].pop_front();
                p = first_one(ack);
                chk($sformatf("dut%0d_ack_port", d), 32'(p), 32'(e.port));
                chk($sformatf("dut%0d_ack_cycle", d), 32'(cyc), 32'(e.cyc));
                chk($sformatf("dut%0d_ack_data", d), 32'(od[p*8 +: 8]), 32'(e.data));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mon(0, 8'(bus_a.o_ack), 64'(bus_a.o_data));
        mon(1, 8'(bus_b.o_ack), 64'(bus_b.o_data));
        mon(2, 8'(bus_c.o_ack), 64'(bus_c.o_data));
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        bus_a.i_req = '0; bus_a.i_rw = '0; bus_a.i_address = '0; bus_a.i_data = '0;
        bus_b.i_req = '0; bus_b.i_rw = '0; bus_b.i_address = '0; bus_b.i_data = '0;
        bus_c.i_req = '0; bus_c.i_rw = '0; bus_c.i_address = '0; bus_c.i_data = '0;

        for (int i = 0; i < 6; i++) begin
            bd_we = 1'b1; bd_addr = pre_addr[i]; bd_data = pre_data[i];
            tick();
        end
        bd_we = 1'b0;

        chk("a_rst_busy", 32'(bus_a.o_busy), 32'd0);
        chk("a_rst_mem_en", 32'(bus_a.o_mem_en), 32'd0);
        chk("a_rst_mem_addr", 32'(bus_a.o_mem_address), 32'd0);
        chk("a_rst_o_data", 32'(bus_a.o_data), 32'd0);
        chk("c_rst_mem_data", 32'(bus_c.o_mem_data), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();

        // Single read on A, request dropped and address changed right after grant
        bus_a.i_req[0] = 1'b1; bus_a.i_rw[0] = 1'b1; bus_a.i_address[15:0] = 16'h1234;
        q[0].push_back(mk(0, 8'hA5, cyc + 2));
        tick();
        chk("a_rd_mem_en", 32'(bus_a.o_mem_en), 32'd1);
        chk("a_rd_mem_wea", 32'(bus_a.o_mem_wea), 32'd0);
        chk("a_rd_mem_addr", 32'(bus_a.o_mem_address), 32'h1234);
        chk("a_rd_busy", 32'(bus_a.o_busy), 32'd1);
        bus_a.i_req[0] = 1'b0; bus_a.i_address[15:0] = 16'hBEEF;
        tick();
        chk("a_done_mem_en", 32'(bus_a.o_mem_en), 32'd0);
        chk("a_done_addr_held", 32'(bus_a.o_mem_address), 32'h1234);
        tick();
        chk("a_idle_busy", 32'(bus_a.o_busy), 32'd0);
        bd_we = 1'b1; bd_addr = 8'h34; bd_data = 8'h00;
        tick();
        bd_we = 1'b0;
        tick();
        chk("a_hold_p0", 32'(bus_a.o_data[7:0]), 32'hA5);

        // Write then read on A port 1
        bus_a.i_req[1] = 1'b1; bus_a.i_rw[1] = 1'b0;
        bus_a.i_address[31:16] = 16'h0200; bus_a.i_data[15:8] = 8'h3C;
        q[0].push_back(mk(1, 8'h00, cyc + 2));
        tick();
        chk("a_wr_mem_en", 32'(bus_a.o_mem_en), 32'd1);
        chk("a_wr_mem_wea", 32'(bus_a.o_mem_wea), 32'd1);
        chk("a_wr_mem_addr", 32'(bus_a.o_mem_address), 32'h0200);
        chk("a_wr_mem_data", 32'(bus_a.o_mem_data), 32'h3C);
        bus_a.i_data[15:8] = 8'hFF;
        tick();
        chk("a_wr_wea_one_cycle", 32'(bus_a.o_mem_wea), 32'd0);
        bus_a.i_req[1] = 1'b0;
        tick();
        chk("a_wr_mem_data_held", 32'(bus_a.o_mem_data), 32'h3C);
        bus_a.i_req[1] = 1'b1; bus_a.i_rw[1] = 1'b1;
        q[0].push_back(mk(1, 8'h3C, cyc + 2));
        tick();
        tick();
        bus_a.i_req[1] = 1'b0;
        tick();
        chk("a_hold_p1", 32'(bus_a.o_data[15:8]), 32'h3C);

        // Fixed priority on B: port 0 monopolises until it drops, then port 1
        for (int p = 0; p < 4; p++) begin
            bus_b.i_req[p] = 1'b1; bus_b.i_rw[p] = 1'b1;
            bus_b.i_address[p*16 +: 16] = 16'h0010 + 16'(p);
        end
        for (int k = 0; k < 4; k++) q[1].push_back(mk(0, 8'h50, cyc + 2 + 3 * k));
        repeat (11) tick();
        bus_b.i_req[0] = 1'b0;
        q[1].push_back(mk(1, 8'h51, cyc + 3));
        repeat (3) tick();
        bus_b.i_req = '0;
        tick();
        chk("b_idle_busy", 32'(bus_b.o_busy), 32'd0);

        // Round-robin on C, latency 3: each port drops in its ack cycle and re-raises
        for (int p = 0; p < 3; p++) begin
            bus_c.i_req[p] = 1'b1; bus_c.i_rw[p] = 1'b1;
            bus_c.i_address[p*16 +: 16] = 16'h0010 + 16'(p);
        end
        for (int k = 0; k < 6; k++) q[2].push_back(mk(k % 3, 8'(8'h50 + k % 3), cyc + 4 + 5 * k));
        repeat (29) begin
            tick();
            for (int p = 0; p < 3; p++) bus_c.i_req[p] = !bus_c.o_ack[p];
        end
        bus_c.i_req = '0;
        tick();
        chk("c_rr_idle_busy", 32'(bus_c.o_busy), 32'd0);

        // Latency 3 read: memory changes during WAIT, DONE-cycle value must be delivered
        bus_c.i_req[1] = 1'b1; bus_c.i_address[31:16] = 16'h0020;
        q[2].push_back(mk(1, 8'h77, cyc + 4));
        tick();
        chk("c_lat_mem_en", 32'(bus_c.o_mem_en), 32'd1);
        tick();
        chk("c_wait_mem_en", 32'(bus_c.o_mem_en), 32'd0);
        chk("c_wait_busy", 32'(bus_c.o_busy), 32'd1);
        bd_we = 1'b1; bd_addr = 8'h20; bd_data = 8'h77;
        tick();
        bd_we = 1'b0;
        chk("c_wait2_busy", 32'(bus_c.o_busy), 32'd1);
        tick();
        bus_c.i_req[1] = 1'b0;
        tick();
        chk("c_lat_hold_p1", 32'(bus_c.o_data[15:8]), 32'h77);

        // Reset during WAIT abandons the access and re-arms round-robin at port 0
        bus_c.i_req[0] = 1'b1;
        tick();
        tick();
        chk("c_pre_rst_busy", 32'(bus_c.o_busy), 32'd1);
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        chk("c_rst_busy", 32'(bus_c.o_busy), 32'd0);
        chk("c_rst_ack", 32'(bus_c.o_ack), 32'd0);
        chk("c_rst_mem_en", 32'(bus_c.o_mem_en), 32'd0);
        chk("c_rst_mem_addr", 32'(bus_c.o_mem_address), 32'd0);
        chk("c_rst_mem_data", 32'(bus_c.o_mem_data), 32'd0);
        chk("c_rst_o_data", 32'(bus_c.o_data), 32'd0);
        bus_c.i_req = 3'b111;
        q[2].push_back(mk(0, 8'h50, cyc + 4));
        repeat (4) tick();
        bus_c.i_req = '0;
        repeat (3) tick();

        chk("a_queue_drained", 32'(q[0].size()), 32'd0);
        chk("b_queue_drained", 32'(q[1].size()), 32'd0);
        chk("c_queue_drained", 32'(q[2].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
